dma_rd_responder: RTL

- Memory-side responder for the DMA read engine's fetch protocol.
- Services descriptor fetches (fetch_descp/ack_fetch_descp/descpdata_valid + 4 descriptor dwords) and data fetches (fetch_data/ack_fetch_data/datafifo_wrdata stream).
- Reads from a 1-cycle-latency synchronous dword memory port.
- Sits between the DMA read top and the bus/memory model; used as the synthesizable bus-side model in system sims.

---
 rtl/dma_rd_responder.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/dma_rd_responder.sv
// Memory-side responder for the DMA read engine's descriptor and data fetch protocol.
// Optional build macro DMA_RSP_BSWAP_EN byte-swaps every returned dword.
module dma_rd_responder #(
  parameter int MEM_AW  = 10,
  parameter int ACK_DLY = 1
) (
  input  logic              clk,
  input  logic              rstb,
  input  logic              fetch_descp,
  input  logic [31:0]       addr_descp,
  input  logic [7:0]        length_descp,
  output logic              ack_fetch_descp,
  output logic              descpdata_valid,
  output logic [31:0]       descp_dword0,
  output logic [31:0]       descp_dword1,
  output logic [31:0]       descp_dword2,
  output logic [31:0]       descp_dword3,
  input  logic              fetch_data,
  input  logic [31:0]       addr_data,
  input  logic [7:0]        length_data,
  output logic              ack_fetch_data,
  output logic [31:0]       datafifo_wrdata,
  output logic              datafifo_datavalid,
  input  logic              rsp_stall,
  output logic              mem_rden,
  output logic [MEM_AW-1:0] mem_addr,
  input  logic [31:0]       mem_rddata,
  output logic              busy
);

  typedef enum logic [2:0] {IDLE, ACKW, DRD, DLAST, DVAL, FRD, FLAST} state_t;

  state_t            state_q, state_d;
  logic              is_data_q, is_data_d;
  logic [MEM_AW-1:0] base_q, base_d;
  logic [6:0]        beats_q, beats_d;
  logic [6:0]        issue_cnt_q, issue_cnt_d;
  logic [1:0]        ret_cnt_q, ret_cnt_d;
  logic [3:0]        dly_q, dly_d;
  logic              ack_descp_q, ack_descp_d;
  logic              ack_data_q, ack_data_d;
  logic              desc_valid_q, desc_valid_d;
  logic              datavalid_q, datavalid_d;
  logic              rvalid_q, rvalid_d;
  logic              mem_rden_q, mem_rden_d;
  logic [MEM_AW-1:0] mem_addr_q, mem_addr_d;
  logic              busy_q, busy_d;
  logic [31:0]       dword_q [4];
  logic [31:0]       dword_d [4];

  logic [8:0]        data_len_rnd;
  logic [31:0]       rd_word;
  logic              unused_bits;

  function automatic logic [31:0] ret_fmt(input logic [31:0] w);
`ifdef DMA_RSP_BSWAP_EN
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
    return w;
`endif
  endfunction

  // Descriptor length is fixed at 4 dwords and only dword address bits reach memory.
  assign unused_bits  = ^{length_descp, addr_descp, addr_data};
  assign data_len_rnd = {1'b0, length_data} + 9'd3;
  assign rd_word      = ret_fmt(mem_rddata);

  always_comb begin
    // NOTE: every variable gets a default here so no path leaves it unassigned (no latches).
    state_d      = state_q;
    is_data_d    = is_data_q;
    base_d       = base_q;
    beats_d      = beats_q;
    issue_cnt_d  = issue_cnt_q;
    ret_cnt_d    = ret_cnt_q;
    dly_d        = dly_q;
    ack_descp_d  = 1'b0;
    ack_data_d   = 1'b0;
    desc_valid_d = 1'b0;
    mem_rden_d   = 1'b0;
    mem_addr_d   = mem_addr_q;
    dword_d      = dword_q;
    rvalid_d     = mem_rden_q;
    datavalid_d  = mem_rden_q && is_data_q;

    // Memory data is valid the cycle after each issued read.
    if (rvalid_q && !is_data_q) begin
      dword_d[ret_cnt_q] = rd_word;
      ret_cnt_d          = ret_cnt_q + 2'd1;
    end

    case (state_q)
      IDLE: begin
        if (fetch_descp || fetch_data) begin
          is_data_d   = !fetch_descp;
          base_d      = fetch_descp ? addr_descp[MEM_AW+1:2] : addr_data[MEM_AW+1:2];
          beats_d     = fetch_descp ? 7'd4 : data_len_rnd[8:2];
          dly_d       = 4'(ACK_DLY);
          issue_cnt_d = '0;
          ret_cnt_d   = '0;
          state_d     = ACKW;
        end
      end
      ACKW: begin
        if (dly_q <= 4'd1) begin
          ack_descp_d = !is_data_q;
          ack_data_d  = is_data_q;
          if (!is_data_q)           state_d = DRD;
          else if (beats_q == '0)   state_d = IDLE;
          else                      state_d = FRD;
        end else begin
          dly_d = dly_q - 4'd1;
        end
      end
      DRD, FRD: begin
        if (!rsp_stall) begin
          mem_rden_d  = 1'b1;
          mem_addr_d  = base_q + MEM_AW'(issue_cnt_q);
          issue_cnt_d = issue_cnt_q + 7'd1;
          if (issue_cnt_q == beats_q - 7'd1)
            state_d = (state_q == DRD) ? DLAST : FLAST;
        end
      end
      DLAST: begin
        if (rvalid_q && ret_cnt_q == 2'd3) begin
          desc_valid_d = 1'b1;
          state_d      = DVAL;
        end
      end
      DVAL:    state_d = IDLE;
      // Stay until the last beat is on the output, then release.
      FLAST:   if (!mem_rden_q) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q      <= IDLE;
      is_data_q    <= 1'b0;
      base_q       <= '0;
      beats_q      <= '0;
      issue_cnt_q  <= '0;
      ret_cnt_q    <= '0;
      dly_q        <= '0;
      ack_descp_q  <= 1'b0;
      ack_data_q   <= 1'b0;
      desc_valid_q <= 1'b0;
      datavalid_q  <= 1'b0;
      rvalid_q     <= 1'b0;
      mem_rden_q   <= 1'b0;
      mem_addr_q   <= '0;
      busy_q       <= 1'b0;
      // NOTE: the dword registers are visible outputs, so they are reset like any other flop.
      dword_q      <= '{default: '0};
    end else begin
      // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
      state_q      <= state_d;
      is_data_q    <= is_data_d;
      base_q       <= base_d;
      beats_q      <= beats_d;
      issue_cnt_q  <= issue_cnt_d;
      ret_cnt_q    <= ret_cnt_d;
      dly_q        <= dly_d;
      ack_descp_q  <= ack_descp_d;
      ack_data_q   <= ack_data_d;
      desc_valid_q <= desc_valid_d;
      datavalid_q  <= datavalid_d;
      rvalid_q     <= rvalid_d;
      mem_rden_q   <= mem_rden_d;
      mem_addr_q   <= mem_addr_d;
      busy_q       <= busy_d;
      dword_q      <= dword_d;
    end
  end

  assign ack_fetch_descp    = ack_descp_q;
  assign ack_fetch_data     = ack_data_q;
  assign descpdata_valid    = desc_valid_q;
  assign descp_dword0       = dword_q[0];
  assign descp_dword1       = dword_q[1];
  assign descp_dword2       = dword_q[2];
  assign descp_dword3       = dword_q[3];
  assign datafifo_datavalid = datavalid_q;
  assign datafifo_wrdata    = datavalid_q ? rd_word : 32'h0;
  assign mem_rden           = mem_rden_q;
  assign mem_addr           = mem_addr_q;
  assign busy               = busy_q;

endmodule
